// File: rtl/iroh_pkg.sv
// Shared Iroh definitions: loader FSM states, bus widths and the CPU opcode set.
package iroh_pkg;

    localparam int ADDR_W = 8;
    localparam int WORD_W = 16;

    localparam logic [3:0] MOV = 4'b0000;
    localparam logic [3:0] JMP = 4'b0001;
    localparam logic [3:0] JEZ = 4'b0010;
    localparam logic [3:0] ADD = 4'b1000;
    localparam logic [3:0] SUB = 4'b1001;

    typedef enum logic [2:0] {
        COUNT,
        HI,
        LO,
        WRITE,
        CHECK,
        RUN,
        ERROR
    } load_state_t;

endpackage

// File: rtl/iroh_word_assembler.sv
// Pairs a high byte with the following low byte into one instruction word.
// The word is presented combinationally with the low byte so the loader can register it on the same edge.
module iroh_word_assembler
    import iroh_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_hi_we,
    input  logic              i_lo_we,
    input  logic [7:0]        i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_valid
);

    logic [7:0] r_hi;

    // Clearing on reset drops any half-received word.
    always_ff @(posedge clk) begin
        if (rst)
            r_hi <= 8'h00;
        else if (i_hi_we)
            r_hi <= i_byte;
    end

    assign o_word       = {r_hi, i_byte};
    assign o_word_valid = i_lo_we;

endmodule

// File: rtl/iroh_boot_loader.sv
// Iroh boot loader: streams count + words into CPU memory, then releases cpu_rst.
// Define IROH_BOOT_CHECKSUM_EN to require a trailer byte making the 8-bit stream sum zero.
module iroh_boot_loader
    import iroh_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LOAD_BASE  = 8'h00,
    parameter int                WRITE_HOLD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    localparam logic [3:0] HOLD_LAST = 4'(WRITE_HOLD - 1);
`ifdef IROH_BOOT_CHECKSUM_EN
    localparam load_state_t AFTER_LAST = CHECK;
`else
    localparam load_state_t AFTER_LAST = RUN;
`endif

    load_state_t       r_state, w_state_nxt;
    logic              r_in_ready;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_wr;
    logic [WORD_W-1:0] r_mem_wdata;
    logic              r_cpu_rst;
    logic              r_done;
    logic [8:0]        r_remaining;
    logic [3:0]        r_hold;

    logic              w_xfer;
    logic              w_write_end;
    logic [WORD_W-1:0] w_word;
    logic              w_word_valid;
    logic [7:0]        w_sum_nxt;

    assign w_xfer      = in_valid && r_in_ready;
    assign w_write_end = (r_state == WRITE) && (r_hold == 4'd0);

    iroh_word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_hi_we      ((r_state == HI) && w_xfer),
        .i_lo_we      ((r_state == LO) && w_xfer),
        .i_byte       (in_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

`ifdef IROH_BOOT_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_error;

    assign w_sum_nxt = r_sum + in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum   <= 8'h00;
            r_error <= 1'b0;
        end else begin
            if (w_xfer)
                r_sum <= w_sum_nxt;
            r_error <= (w_state_nxt == ERROR);
        end
    end

    assign error = r_error;
`else
    assign w_sum_nxt = 8'h00;
    assign error     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= COUNT;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COUNT:   if (w_xfer) w_state_nxt = HI;
            HI:      if (w_xfer) w_state_nxt = LO;
            LO:      if (w_xfer) w_state_nxt = WRITE;
            WRITE:   if (w_write_end) w_state_nxt = (r_remaining == 9'd1) ? AFTER_LAST : HI;
            CHECK:   if (w_xfer) w_state_nxt = (w_sum_nxt == 8'h00) ? RUN : ERROR;
            RUN:     w_state_nxt = RUN;
            ERROR:   w_state_nxt = ERROR;
            default: w_state_nxt = COUNT;
        endcase
    end

    // Handshake and CPU-control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_mem_addr  <= LOAD_BASE;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= '0;
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_remaining <= 9'd0;
            r_hold      <= 4'd0;
        end else begin
            r_in_ready <= (w_state_nxt inside {COUNT, HI, LO, CHECK});
            r_cpu_rst  <= (w_state_nxt != RUN);
            r_done     <= (w_state_nxt == RUN);
            if ((r_state == COUNT) && w_xfer)
                r_remaining <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
            if (w_word_valid) begin
                r_mem_wr    <= 1'b1;
                r_mem_wdata <= w_word;
                r_hold      <= HOLD_LAST;
            end else if (w_write_end) begin
                r_mem_wr    <= 1'b0;
                r_mem_addr  <= r_mem_addr + 1'b1;
                r_remaining <= r_remaining - 1'b1;
            end else if (r_state == WRITE) begin
                r_hold <= r_hold - 1'b1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_addr  = r_mem_addr;
    assign mem_en    = r_mem_wr;
    assign mem_wen   = r_mem_wr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_rst   = r_cpu_rst;
    assign done      = r_done;

endmodule

// File: tb/tb_iroh_boot_loader.sv
// Scoreboard bench for iroh_boot_loader: random byte streams, write checks in a monitor.
module tb_iroh_boot_loader;

    localparam logic [7:0] LB = 8'hFE;
    localparam int         WH = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [7:0]  mem_addr;
    logic        mem_en;
    logic        mem_wen;
    logic [15:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    iroh_boot_loader #(.LOAD_BASE(LB), .WRITE_HOLD(WH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
        bit          last;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] wq[$];
    logic [15:0] ref_mem[256];
    logic [15:0] dut_mem[256];
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: each write burst is matched against the next scoreboard entry.
    bit          m_in_wr = 0;
    int          m_hold = 0;
    logic [7:0]  m_addr;
    logic [15:0] m_data;
    bit          m_last = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_in_wr = 0;
        end else if (mem_en && !m_in_wr) begin
            m_in_wr = 1;
            m_hold  = 1;
            m_addr  = mem_addr;
            m_data  = mem_wdata;
            dut_mem[mem_addr] = mem_wdata;
            check("write wen", {31'd0, mem_wen}, 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected write", 32'd1, 32'd0);
                m_last = 0;
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write addr", {24'd0, mem_addr}, {24'd0, e.addr});
                check("write data", {16'd0, mem_wdata}, {16'd0, e.data});
                m_last = e.last;
            end
        end else if (mem_en && m_in_wr) begin
            m_hold++;
            check("wdata stable", {16'd0, mem_wdata}, {16'd0, m_data});
            check("in_ready during write", {31'd0, in_ready}, 32'd0);
        end else if (!mem_en && m_in_wr) begin
            m_in_wr = 0;
            check("hold cycles", m_hold, WH);
            check("addr increment", {24'd0, mem_addr}, {24'd0, m_addr + 8'd1});
            if (m_last) begin
`ifdef IROH_BOOT_CHECKSUM_EN
                check("trailer ready", {31'd0, in_ready}, 32'd1);
                check("cpu_rst held for trailer", {31'd0, cpu_rst}, 32'd1);
`else
                check("cpu_rst release latency", {31'd0, cpu_rst}, 32'd0);
                check("done latency", {31'd0, done}, 32'd1);
`endif
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        if ($urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL in_ready timeout: got 0 expected 1");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_flag(input bit want_err);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (want_err ? error : done) break;
        end
    endtask

    // Reference: word i of a load lands at LB+i (mod 256); stream sum including trailer is zero.
    task automatic run_load(input logic [7:0] nbyte, input bit bad_trailer);
        int         cnt;
        logic [7:0] sum;
        logic [7:0] a;
        cnt = wq.size();
        sum = nbyte;
        send_byte(nbyte);
        for (int i = 0; i < cnt; i++) begin
            a = LB + 8'(i);
            exp_q.push_back('{addr: a, data: wq[i], last: (i == cnt - 1)});
            ref_mem[a] = wq[i];
            sum = sum + wq[i][15:8] + wq[i][7:0];
            send_byte(wq[i][15:8]);
            send_byte(wq[i][7:0]);
        end
`ifdef IROH_BOOT_CHECKSUM_EN
        send_byte(bad_trailer ? (8'h00 - sum - 8'h01) : (8'h00 - sum));
`endif
        wait_flag(bad_trailer);
        if (bad_trailer) begin
            check("error flag", {31'd0, error}, 32'd1);
            check("error cpu_rst", {31'd0, cpu_rst}, 32'd1);
            in_valid = 1'b1;
            repeat (5) @(negedge clk);
            check("error sticky", {31'd0, error}, 32'd1);
            check("error in_ready", {31'd0, in_ready}, 32'd0);
            check("error done", {31'd0, done}, 32'd0);
            in_valid = 1'b0;
        end else begin
            check("done", {31'd0, done}, 32'd1);
            check("cpu_rst low in RUN", {31'd0, cpu_rst}, 32'd0);
            check("in_ready low in RUN", {31'd0, in_ready}, 32'd0);
            check("mem idle in RUN", {31'd0, mem_en}, 32'd0);
            check("error clear", {31'd0, error}, 32'd0);
            check("final addr", {24'd0, mem_addr}, {24'd0, LB + 8'(cnt)});
        end
        check("scoreboard drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        int mism;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 16'h0000;
            dut_mem[i] = 16'h0000;
        end

        // Reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst in_ready", {31'd0, in_ready}, 32'd0);
        check("rst mem_addr", {24'd0, mem_addr}, {24'd0, LB});
        check("rst mem_en", {31'd0, mem_en}, 32'd0);
        check("rst mem_wen", {31'd0, mem_wen}, 32'd0);
        check("rst mem_wdata", {16'd0, mem_wdata}, 32'd0);
        check("rst cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst error", {31'd0, error}, 32'd0);
        #1;
        rst = 1'b0;

        // Two-word program: MOV ab,#5; ADD ab,#1
        wq = '{16'hF305, 16'h3801};
        run_load(8'd2, 0);

        // Three words across the FF->00 boundary
        do_reset();
        wq.delete();
        for (int i = 0; i < 3; i++) wq.push_back(16'($urandom));
        run_load(8'd3, 0);

        // Reset after the high byte of word 2
        do_reset();
        wq.delete();
        wq.push_back(16'($urandom));
        exp_q.push_back('{addr: LB, data: wq[0], last: 0});
        ref_mem[LB] = wq[0];
        send_byte(8'd2);
        send_byte(wq[0][15:8]);
        send_byte(wq[0][7:0]);
        send_byte(8'($urandom));
        check("mid-load word 1 written", exp_q.size(), 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid-load reset cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("mid-load reset addr", {24'd0, mem_addr}, {24'd0, LB});
        check("mid-load reset done", {31'd0, done}, 32'd0);
        #1;
        rst = 1'b0;
        wq = '{16'hABCD};
        run_load(8'd1, 0);

        // N=0: full 256-word image
        do_reset();
        wq.delete();
        for (int i = 0; i < 256; i++) wq.push_back(16'($urandom));
        run_load(8'd0, 0);

        // Random short images
        for (int t = 0; t < 4; t++) begin
            do_reset();
            wq.delete();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
            run_load(8'(n), 0);
        end

`ifdef IROH_BOOT_CHECKSUM_EN
        do_reset();
        wq = '{16'h1234};
        run_load(8'd1, 1);
`endif

        mism = 0;
        for (int i = 0; i < 256; i++)
            if (dut_mem[i] !== ref_mem[i]) mism++;
        check("memory image", mism, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
